// File: rtl/fifo_unpacker.sv
// Pops wide words from a show-ahead FIFO and replays them as narrow beats,
// least-significant beat first, on a valid/ready stream with no inter-word bubbles.
module fifo_unpacker #(
  parameter int data_width = 32,
  parameter int beat_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_read_data,
  output logic                  fifo_read_enable,
  output logic [beat_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);
  localparam int ratio     = data_width / beat_width;
  localparam int idx_width = (ratio > 1) ? $clog2(ratio) : 1;
  localparam logic [idx_width-1:0] last_idx = idx_width'(ratio - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_reg, state_next;
  logic [data_width-1:0] word_reg, word_next;
  logic [idx_width-1:0]  beat_idx_reg, beat_idx_next;
  logic                  accept, last;

  assign out_valid = (state_reg == ACTIVE);
  assign busy      = (state_reg == ACTIVE);
  assign out_data  = word_reg[int'(beat_idx_reg) * beat_width +: beat_width];
  assign accept    = out_valid && out_ready;
  assign last      = (beat_idx_reg == last_idx);

  // Refill on the last accepted beat so the next word follows with no gap.
  assign fifo_read_enable = !reset && !fifo_empty && ((state_reg == IDLE) || (accept && last));

  always_comb begin
    state_next    = state_reg;
    word_next     = word_reg;
    beat_idx_next = beat_idx_reg;
    if (fifo_read_enable) begin
      state_next    = ACTIVE;
      word_next     = fifo_read_data;
      beat_idx_next = '0;
    end else if (accept && !last) begin
      beat_idx_next = beat_idx_reg + 1'b1;
    end else if (accept && last) begin
      state_next    = IDLE;
      beat_idx_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      word_reg     <= '0;
      beat_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      word_reg     <= word_next;
      beat_idx_reg <= beat_idx_next;
    end
  end
endmodule

// File: tb/tb_fifo_unpacker.sv
// Scoreboard bench for fifo_unpacker: a 32/8 instance for the main scenarios
// and a 32/32 instance for the ratio-1 case, each fed from a queue-modelled FIFO.
module tb_fifo_unpacker;
  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        fifo_empty8 = 1'b1, ren8, out_valid8, busy8, out_ready8 = 1'b1;
  logic [31:0] fifo_data8 = '0;
  logic [7:0]  out_data8;

  logic        fifo_empty32 = 1'b1, ren32, out_valid32, busy32, out_ready32 = 1'b1;
  logic [31:0] fifo_data32 = '0, out_data32;

  logic [31:0] q8[$], q32[$], exp8[$], exp32[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, pops8 = 0, pops32 = 0, acc8 = 0, acc32 = 0;
  int first8 = -1, last8 = -1, first32 = -1, last32 = -1;
  int test_id = 0;
  logic stall_prev8 = 1'b0;
  logic [7:0] held8 = '0;

  fifo_unpacker #(.data_width(32), .beat_width(8)) dut8 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty8), .fifo_read_data(fifo_data8),
    .fifo_read_enable(ren8), .out_data(out_data8), .out_valid(out_valid8),
    .out_ready(out_ready8), .busy(busy8));

  fifo_unpacker #(.data_width(32), .beat_width(32)) dut32 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty32), .fifo_read_data(fifo_data32),
    .fifo_read_enable(ren32), .out_data(out_data32), .out_valid(out_valid32),
    .out_ready(out_ready32), .busy(busy32));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    fifo_empty8  = (q8.size() == 0);
    fifo_data8   = fifo_empty8 ? 32'h0 : q8[0];
    fifo_empty32 = (q32.size() == 0);
    fifo_data32  = fifo_empty32 ? 32'h0 : q32[0];
  endtask

  task automatic push8(input logic [31:0] w);
    q8.push_back(w);
    for (int i = 0; i < 4; i++) exp8.push_back({24'h0, w[i*8 +: 8]});
    refresh();
  endtask

  task automatic push32(input logic [31:0] w);
    q32.push_back(w);
    exp32.push_back(w);
    refresh();
  endtask

  // One clock: pops are sampled at the edge, applied to the FIFO model just after it.
  task automatic step();
    logic p8, p32;
    @(posedge clk);
    p8  = ren8;
    p32 = ren32;
    #1;
    if (p8 && q8.size() != 0) begin void'(q8.pop_front()); pops8++; end
    if (p32 && q32.size() != 0) begin void'(q32.pop_front()); pops32++; end
    refresh();
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp8.size() != 0 || busy8 || exp32.size() != 0 || busy32) && n < 200) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(n < 200), 32'd1);
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      check("ren_in_reset", 32'(ren8), 32'd0);
    end else begin
      if (fifo_empty8) check("ren_while_empty8", 32'(ren8), 32'd0);
      if (fifo_empty32) check("ren_while_empty32", 32'(ren32), 32'd0);
      if (stall_prev8) check("stall_hold", {24'h0, out_data8}, {24'h0, held8});
      if (out_valid8 && !out_ready8) check("stall_no_pop", 32'(ren8), 32'd0);
      if (out_valid8 && out_ready8) begin
        e = (exp8.size() != 0) ? exp8.pop_front() : 32'hDEAD_0000;
        check("beat8", {24'h0, out_data8}, e);
        if (test_id == 3 && out_data8 == 8'h44) check("pop_on_last", 32'(ren8), 32'd1);
        acc8++;
        if (first8 < 0) first8 = cyc;
        last8 = cyc;
      end
      if (out_valid32 && out_ready32) begin
        e = (exp32.size() != 0) ? exp32.pop_front() : 32'hDEAD_0000;
        check("beat32", out_data32, e);
        acc32++;
        if (first32 < 0) first32 = cyc;
        last32 = cyc;
      end
    end
    stall_prev8 = !reset && out_valid8 && !out_ready8;
    held8 = out_data8;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    // 1: reset with a word waiting, then start-up latency
    test_id = 1;
    push8(32'h12345678);
    for (int i = 0; i < 3; i++) step();
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_out_data", {24'h0, out_data8}, 32'h0);
    check("rst_busy", 32'(busy8), 32'd0);
    reset = 1'b0;
    #1;
    check("ren_after_release", 32'(ren8), 32'd1);
    drain();

    // 2: single word, continuous ready
    test_id = 2;
    base = pops8; first8 = -1;
    push8(32'hDDCCBBAA);
    for (int i = 0; i < 5; i++) step();
    check("t2_idle_after", 32'(out_valid8), 32'd0);
    check("t2_pops", 32'(pops8 - base), 32'd1);
    check("t2_span", 32'(last8 - first8), 32'd3);

    // 3: two words back to back
    test_id = 3;
    base = pops8; first8 = -1;
    push8(32'h44332211);
    push8(32'h88776655);
    drain();
    check("t3_pops", 32'(pops8 - base), 32'd2);
    check("t3_no_gap", 32'(last8 - first8), 32'd7);

    // 4: backpressure
    test_id = 4;
    base = acc8;
    push8(32'hDDCCBBAA);
    for (int i = 0; i < 7; i++) begin
      step();
      out_ready8 = pat[i];
      if (i == 1 || i == 2) begin
        #1;
        check("t4_hold_bb", {24'h0, out_data8}, 32'hBB);
      end
    end
    out_ready8 = 1'b1;
    drain();
    check("t4_accepts", 32'(acc8 - base), 32'd4);

    // 5: underflow gap then refill
    test_id = 5;
    push8(32'h0000BEEF);
    drain();
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_gap_valid", 32'(out_valid8), 32'd0);
      check("t5_gap_busy", 32'(busy8), 32'd0);
    end
    push8(32'hCAFEF00D);
    #1;
    check("t5_refill_ren", 32'(ren8), 32'd1);
    step();
    check("t5_resume_valid", 32'(out_valid8), 32'd1);
    check("t5_resume_data", {24'h0, out_data8}, 32'h0D);
    drain();

    // 6: reset in the middle of a word
    test_id = 6;
    push8(32'hDDCCBBAA);
    push8(32'h11223344);
    base = acc8; n = 0;
    while (acc8 < base + 2 && n < 50) begin step(); n++; end
    check("t6_wait", 32'(n < 50), 32'd1);
    reset = 1'b1;
    void'(exp8.pop_front());  // 0xCC is discarded
    void'(exp8.pop_front());  // 0xDD is discarded
    #1;
    check("t6_ren_in_reset", 32'(ren8), 32'd0);
    step();
    check("t6_valid_after_rst", 32'(out_valid8), 32'd0);
    check("t6_fifo_kept", 32'(q8.size()), 32'd1);
    reset = 1'b0;
    drain();

    // 7: ratio 1 instance
    test_id = 7;
    base = pops32; first32 = -1;
    push32(32'h01020304);
    push32(32'hA5A5_5A5A);
    push32(32'hFFFF_0000);
    drain();
    check("t7_pops", 32'(pops32 - base), 32'd3);
    check("t7_no_gap", 32'(last32 - first32), 32'd2);

    check("exp8_empty", 32'(exp8.size()), 32'd0);
    check("exp32_empty", 32'(exp32.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
